// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback byte buffer: widths and the
// transmit-handshake state encoding.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Receiver-side capture, transmitter-side handshake and FIFO status signals
// of the loopback byte buffer. The buffer is the slave; its environment is
// the master.
interface uart_tx_fifo_if #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int ADDR_W = uart_pkg::ADDR_W
);

    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output rx_done, rx_data, tx_busy, ovf_clr,
        input  tx_start, tx_data, count, empty, full, overflow
    );

    modport slave (
        input  rx_done, rx_data, tx_busy, ovf_clr,
        output tx_start, tx_data, count, empty, full, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Full/empty come from the
// count rather than a pointer compare, so the pointers can wrap freely.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the pre-edge count, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (count == '0);
    assign full  = (count == (ADDR_W + 1)'(DEPTH));
    assign rdata = mem[rd_ptr];

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer between UART receiver and transmitter. Received bytes are
// queued in a FIFO and handed to the transmitter one at a time through a
// start/busy handshake; bytes arriving while full are dropped and flagged.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no frame in flight; pops a byte once FIFO non-empty and tx idle
// WAIT_ACK  | tx_start pulsed on entry; waiting for tx_busy to rise
// WAIT_DONE | transmitter shifting the frame; waiting for tx_busy to fall
module uart_tx_fifo
    import uart_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    uart_tx_fifo_if.slave   bus
);

    tx_state_e         state;
    tx_state_e         state_next;
    logic              pop;
    logic              start_next;
    logic [DATA_W-1:0] fifo_rdata;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              overflow_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rx_done),
        .pop   (pop),
        .wdata (bus.rx_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.count    = fifo_count;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;

    // Next-state and pop decision for the transmit handshake.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        start_next = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop        = 1'b1;
                    start_next = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered start pulse and held transmit byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_next;
            tx_start_q <= start_next;
            if (pop) begin
                tx_data_q <= fifo_rdata;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.rx_done && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue of expected bytes is filled as
// bytes are offered and drained as the DUT launches frames.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         stored  = 0;
    logic [7:0] sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        if (stored < 16) begin
            sb.push_back(b);
            stored++;
        end
        tick();
        bus.rx_done = 1'b0;
    endtask

    // Acts as the transmitter: waits for a launch, checks the byte, then
    // holds busy for one frame while checking the byte stays put.
    task automatic serve(input int frame);
        logic [7:0] want;
        int waited;
        waited = 0;
        while (bus.tx_start !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        chk("tx_start_seen", 32'(bus.tx_start), 32'd1);
        if (bus.tx_start !== 1'b1) return;
        chk("queue_has_byte", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        want = sb.pop_front();
        stored--;
        chk("tx_data", 32'(bus.tx_data), 32'(want));
        bus.tx_busy = 1'b1;
        for (int i = 0; i < frame; i++) begin
            tick();
            chk("tx_data_hold", 32'(bus.tx_data), 32'(want));
            chk("no_restart", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_busy = 1'b0;
    endtask

    initial begin
        logic [7:0] want;
        int starts;

        rst         = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.tx_busy = 1'b0;
        bus.ovf_clr = 1'b0;

        // reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);

        // single byte with exact latency
        push_byte(8'h55);
        chk("single_count", 32'(bus.count), 32'd1);
        chk("single_empty", 32'(bus.empty), 32'd0);
        chk("single_start_early", 32'(bus.tx_start), 32'd0);
        tick();
        chk("single_start", 32'(bus.tx_start), 32'd1);
        want = sb.pop_front();
        stored--;
        chk("single_data", 32'(bus.tx_data), 32'(want));
        chk("single_count_pop", 32'(bus.count), 32'd0);
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_no_restart", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_busy = 1'b0;
        tick();
        chk("single_state_idle", 32'(dut.state), 32'(IDLE));
        chk("single_empty_end", 32'(bus.empty), 32'd1);

        // burst while transmitter busy
        bus.tx_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            chk("burst_no_start", 32'(bus.tx_start), 32'd0);
        end
        chk("burst_count", 32'(bus.count), 32'd5);
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) serve(8);
        tick();
        chk("burst_empty", 32'(bus.empty), 32'd1);

        // fill, drop, overflow set-wins and clear
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i));
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_overflow", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        push_byte(8'h77);
        bus.ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        chk("ovf_count_kept", 32'(bus.count), 32'd16);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 16; i++) serve(3);
        tick();
        chk("full_drain_empty", 32'(bus.empty), 32'd1);
        chk("full_no_extra", 32'(bus.tx_start), 32'd0);

        // pointer wrap and simultaneous push/pop
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 12; i++) push_byte(8'h40 + 8'(i));
        chk("wrap_count12", 32'(bus.count), 32'd12);
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 12; i++) serve(2);
        tick();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i));
        chk("wrap_count9", 32'(bus.count), 32'd9);
        bus.rx_data = 8'h69;
        bus.rx_done = 1'b1;
        bus.tx_busy = 1'b0;
        sb.push_back(8'h69);
        stored++;
        tick();
        bus.rx_done = 1'b0;
        chk("simul_count", 32'(bus.count), 32'd9);
        chk("simul_start", 32'(bus.tx_start), 32'd1);
        for (int i = 0; i < 10; i++) serve(2);
        tick();
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // reset while in WAIT_DONE with 3 bytes queued
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        bus.tx_busy = 1'b0;
        tick();
        chk("mid_start", 32'(bus.tx_start), 32'd1);
        chk("mid_count", 32'(bus.count), 32'd3);
        bus.tx_busy = 1'b1;
        tick();
        chk("mid_state", 32'(dut.state), 32'(WAIT_DONE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        sb.delete();
        stored = 0;
        bus.tx_busy = 1'b0;
        push_byte(8'hA5);
        serve(4);
        tick();
        chk("mid_after_empty", 32'(bus.empty), 32'd1);

        // transmitter never acknowledges
        push_byte(8'h3C);
        tick();
        chk("stall_start", 32'(bus.tx_start), 32'd1);
        want = sb.pop_front();
        stored--;
        chk("stall_data", 32'(bus.tx_data), 32'(want));
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) push_byte(8'h3D);
            else if (i == 7) push_byte(8'h3E);
            else tick();
            if (bus.tx_start === 1'b1) starts++;
        end
        chk("stall_no_second_start", 32'(starts), 32'd0);
        chk("stall_state", 32'(dut.state), 32'(WAIT_ACK));
        chk("stall_count", 32'(bus.count), 32'd2);
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
        serve(2);
        serve(2);
        tick();
        chk("stall_drain_empty", 32'(bus.empty), 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
